// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM state encodings.
package sdram_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    // state    | meaning
    // IDLE     | pick a grant each cycle (download write first, then round-robin read)
    // ISSUE_RD | read request presented to the controller, waiting for sdram_ack
    // ISSUE_WR | download write presented to the controller, waiting for sdram_ack
    localparam arb_state_t ST_IDLE     = 2'd0;
    localparam arb_state_t ST_ISSUE_RD = 2'd1;
    localparam arb_state_t ST_ISSUE_WR = 2'd2;

endpackage

// File: rtl/sdram_arbiter_tag_fifo.sv
// In-order FIFO of granted port indices, one entry per outstanding read.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; a pop from an empty FIFO is ignored.
module tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous reset (flush).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; entries are only read once pushed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between NUM_PORTS round-robin readers and
// the ROM download writer (absolute priority). Read completions are routed
// back to their requester through an in-order tag FIFO.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_WIDTH  = 23,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NUM_PORTS-1:0]            rd_req_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_PORTS-1:0]            rd_ack_o,
    output logic [NUM_PORTS-1:0]            rd_valid_o,
    input  logic                            dl_active_i,
    input  logic                            dl_req_i,
    input  logic [ADDR_WIDTH-1:0]           dl_addr_i,
    input  logic [DATA_WIDTH-1:0]           dl_data_i,
    output logic                            dl_ack_o,
    output logic [ADDR_WIDTH-1:0]           sdram_addr_o,
    output logic [DATA_WIDTH-1:0]           sdram_data_o,
    output logic                            sdram_we_o,
    output logic                            sdram_req_o,
    input  logic                            sdram_ack_i,
    input  logic                            sdram_valid_i,
    output logic [$clog2(MAX_PENDING):0]    pending_cnt_o,
    output logic                            err_orphan_o
);

    localparam int TAG_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t            state_q, state_d;
    logic [TAG_W-1:0]      grant_q, grant_d;
    logic [TAG_W-1:0]      rr_q, rr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic                  req_q, req_d;
    logic                  orphan_q, orphan_d;

    logic                  pick_found;
    logic [TAG_W-1:0]      pick_idx;
    logic [TAG_W-1:0]      cand;
    int                    cand_int;

    logic                  ack_rd;
    logic                  ack_wr;
    logic                  fifo_pop;
    logic [TAG_W-1:0]      fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Acks and routing pulses are suppressed while reset is asserted so that
    // nothing leaks out of a half-finished transaction.
    assign ack_rd   = (state_q == ST_ISSUE_RD) && sdram_ack_i && !reset_i;
    assign ack_wr   = (state_q == ST_ISSUE_WR) && sdram_ack_i && !reset_i;
    assign fifo_pop = sdram_valid_i && !fifo_empty && !reset_i;

    assign rd_ack_o     = ack_rd   ? (NUM_PORTS'(1) << grant_q)   : '0;
    assign rd_valid_o   = fifo_pop ? (NUM_PORTS'(1) << fifo_head) : '0;
    assign dl_ack_o     = ack_wr;
    assign sdram_addr_o = addr_q;
    assign sdram_data_o = data_q;
    assign sdram_we_o   = we_q;
    assign sdram_req_o  = req_q;
    assign err_orphan_o = orphan_q;

    tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (ack_rd),
        .pop_i   (fifo_pop),
        .din_i   (grant_q),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pending_cnt_o)
    );

    // Round-robin search: first requesting port at or after rr_q; scanned from
    // the far end so the nearest match is the last one written.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        cand_int   = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand_int = (int'(rr_q) + k) % NUM_PORTS;
            cand     = TAG_W'(cand_int);
            if (rd_req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Grant FSM and registered controller-side request.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = we_q;
        req_d    = req_q;
        orphan_d = orphan_q | (sdram_valid_i & fifo_empty);
        case (state_q)
            ST_IDLE: begin
                if (dl_active_i && dl_req_i) begin
                    state_d = ST_ISSUE_WR;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = dl_addr_i;
                    data_d  = dl_data_i;
                end else if (!dl_active_i && !fifo_full && pick_found) begin
                    state_d = ST_ISSUE_RD;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    grant_d = pick_idx;
                    addr_d  = rd_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
            ST_ISSUE_RD: begin
                if (sdram_ack_i) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    rr_d    = (grant_q == TAG_W'(NUM_PORTS - 1)) ? '0 : grant_q + TAG_W'(1);
                end
            end
            ST_ISSUE_WR: begin
                if (sdram_ack_i) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            req_q    <= 1'b0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            req_q    <= req_d;
            orphan_q <= orphan_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int NP = 4;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int MP = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   rd_req;
    logic [NP*AW-1:0] rd_addr;
    logic [NP-1:0]   rd_ack;
    logic [NP-1:0]   rd_valid;
    logic            dl_active;
    logic            dl_req;
    logic [AW-1:0]   dl_addr;
    logic [DW-1:0]   dl_data;
    logic            dl_ack;
    logic [AW-1:0]   sdram_addr;
    logic [DW-1:0]   sdram_data;
    logic            sdram_we;
    logic            sdram_req;
    logic            sdram_ack;
    logic            sdram_valid;
    logic [$clog2(MP):0] pending_cnt;
    logic            err_orphan;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .NUM_PORTS   (NP),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_PENDING (MP)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .rd_req_i      (rd_req),
        .rd_addr_i     (rd_addr),
        .rd_ack_o      (rd_ack),
        .rd_valid_o    (rd_valid),
        .dl_active_i   (dl_active),
        .dl_req_i      (dl_req),
        .dl_addr_i     (dl_addr),
        .dl_data_i     (dl_data),
        .dl_ack_o      (dl_ack),
        .sdram_addr_o  (sdram_addr),
        .sdram_data_o  (sdram_data),
        .sdram_we_o    (sdram_we),
        .sdram_req_o   (sdram_req),
        .sdram_ack_i   (sdram_ack),
        .sdram_valid_i (sdram_valid),
        .pending_cnt_o (pending_cnt),
        .err_orphan_o  (err_orphan)
    );

    typedef struct {
        logic [NP-1:0] req;
        int            exp_port;
        int            ack_delay;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [AW-1:0] port_addr(input int i);
        return AW'((i + 1) * 'h100);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        rd_req      = '0;
        dl_active   = 1'b0;
        dl_req      = 1'b0;
        dl_addr     = '0;
        dl_data     = '0;
        sdram_ack   = 1'b0;
        sdram_valid = 1'b0;
        for (int i = 0; i < NP; i++) rd_addr[i*AW +: AW] = port_addr(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Advance until sdram_req is seen, bounded.
    task automatic wait_req(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!sdram_req && n < 12);
        check(name, sdram_req, 1'b1);
    endtask

    task automatic read_txn(input logic [NP-1:0] req, input int exp_port, input int ack_delay,
                            input string name);
        @(negedge clk);
        rd_req = req;
        wait_req({name, "_req"});
        check({name, "_addr"}, sdram_addr, port_addr(exp_port));
        check({name, "_we"}, sdram_we, 1'b0);
        repeat (ack_delay) @(negedge clk);
        @(negedge clk);
        sdram_ack = 1'b1;
        #1;
        check({name, "_rd_ack"}, rd_ack, NP'(1) << exp_port);
        @(negedge clk);
        sdram_ack = 1'b0;
        rd_req    = '0;
        #1;
        check({name, "_gap_req"}, sdram_req, 1'b0);
        check({name, "_ack_pulse"}, rd_ack, '0);
    endtask

    task automatic pop_check(input int exp_port, input string name);
        @(negedge clk);
        sdram_valid = 1'b1;
        #1;
        check(name, rd_valid, NP'(1) << exp_port);
        @(negedge clk);
        sdram_valid = 1'b0;
    endtask

    // Transaction-level reference model state for the randomized run.
    int              mq[$];
    int              busy;      // 0 none, 1 read, 2 write
    int              bport;
    logic [AW-1:0]   baddr;
    logic [DW-1:0]   bdata;
    int              rr;
    logic [NP-1:0]   acked_last;
    logic            dl_acked_last;
    logic [NP-1:0]   e_rd_ack;
    logic [NP-1:0]   e_valid;
    logic            e_dl_ack;
    int              occ;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0101, 0, 0};
        tbl[1] = '{4'b0101, 2, 1};
        tbl[2] = '{4'b0001, 0, 2};
        tbl[3] = '{4'b1000, 3, 0};
        tbl[4] = '{4'b1111, 0, 1};
        tbl[5] = '{4'b0110, 1, 2};
        tbl[6] = '{4'b0011, 0, 0};
        tbl[7] = '{4'b1100, 2, 1};
        tbl[8] = '{4'b0111, 0, 2};
        tbl[9] = '{4'b1111, 1, 0};

        reset = 1'b1;
        clear_inputs();
        do_reset();
        #1;
        check("rst_req", sdram_req, 1'b0);
        check("rst_we", sdram_we, 1'b0);
        check("rst_addr", sdram_addr, '0);
        check("rst_data", sdram_data, '0);
        check("rst_rd_ack", rd_ack, '0);
        check("rst_rd_valid", rd_valid, '0);
        check("rst_dl_ack", dl_ack, 1'b0);
        check("rst_pending", pending_cnt, '0);
        check("rst_orphan", err_orphan, 1'b0);

        // Two ports, ack two cycles after request: port0 then port2, rr lands on 3.
        read_txn(4'b0101, 0, 1, "a_p0");
        read_txn(4'b0100, 2, 1, "a_p2");
        check("a_pending2", pending_cnt, 2);
        pop_check(0, "a_valid0");
        pop_check(2, "a_valid2");
        #1;
        check("a_pending0", pending_cnt, 0);
        read_txn(4'b1001, 3, 0, "a_rr3");
        pop_check(3, "a_valid3");

        // Vector table: rr pointer is 0 here.
        for (int v = 0; v < 10; v++) begin
            read_txn(tbl[v].req, tbl[v].exp_port, tbl[v].ack_delay, $sformatf("tbl%0d", v));
            check($sformatf("tbl%0d_pend", v), pending_cnt, 1);
            pop_check(tbl[v].exp_port, $sformatf("tbl%0d_valid", v));
        end

        // All ports requesting, immediate acks, each ack coincides with the
        // previous read's completion.
        do_reset();
        @(negedge clk);
        rd_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_req($sformatf("b_req%0d", k));
            check($sformatf("b_addr%0d", k), sdram_addr, port_addr(k % NP));
            sdram_ack   = 1'b1;
            sdram_valid = (k > 0);
            #1;
            check($sformatf("b_ack%0d", k), rd_ack, NP'(1) << (k % NP));
            if (k > 0) check($sformatf("b_valid%0d", k), rd_valid, NP'(1) << (k - 1));
            @(negedge clk);
            sdram_ack   = 1'b0;
            sdram_valid = 1'b0;
            #1;
            check($sformatf("b_gap%0d", k), sdram_req, 1'b0);
            check($sformatf("b_pulse%0d", k), rd_ack, '0);
            check($sformatf("b_pend%0d", k), pending_cnt, 1);
        end
        rd_req = '0;
        pop_check(0, "b_valid_last");

        // Fill the tag FIFO, confirm the next read is held off until a completion.
        do_reset();
        for (int p = 0; p < NP; p++) read_txn(NP'(1) << p, p, 0, $sformatf("c_fill%0d", p));
        check("c_pending_full", pending_cnt, 4);
        @(negedge clk);
        rd_req = 4'b0001;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("c_full_block", sdram_req, 1'b0);
        end
        @(negedge clk);
        sdram_valid = 1'b1;
        #1;
        check("c_valid_first", rd_valid, 4'b0001);
        @(negedge clk);
        sdram_valid = 1'b0;
        read_txn(4'b0001, 0, 0, "c_refill");
        check("c_pending_refull", pending_cnt, 4);
        pop_check(1, "c_order1");
        pop_check(2, "c_order2");
        pop_check(3, "c_order3");
        pop_check(0, "c_order0");
        #1;
        check("c_pending_drained", pending_cnt, 0);

        // Download write takes priority; reads stay blocked while dl_active.
        do_reset();
        @(negedge clk);
        rd_req    = 4'b0001;
        dl_active = 1'b1;
        dl_req    = 1'b1;
        dl_addr   = AW'('h1234);
        dl_data   = 32'hDEADBEEF;
        wait_req("e_wr_req");
        check("e_we", sdram_we, 1'b1);
        check("e_addr", sdram_addr, AW'('h1234));
        check("e_data", sdram_data, 32'hDEADBEEF);
        @(negedge clk);
        sdram_ack = 1'b1;
        #1;
        check("e_dl_ack", dl_ack, 1'b1);
        check("e_no_rd_ack", rd_ack, '0);
        @(negedge clk);
        sdram_ack = 1'b0;
        dl_req    = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("e_rd_blocked", sdram_req, 1'b0);
        end
        @(negedge clk);
        dl_active = 1'b0;
        wait_req("e_rd_req");
        check("e_rd_addr", sdram_addr, port_addr(0));
        check("e_rd_we", sdram_we, 1'b0);
        check("e_pending_nowr", pending_cnt, 0);

        // Orphan completion, then reset in the middle of a read issue.
        do_reset();
        @(negedge clk);
        sdram_valid = 1'b1;
        #1;
        check("f_no_valid", rd_valid, '0);
        @(negedge clk);
        sdram_valid = 1'b0;
        #1;
        check("f_orphan_set", err_orphan, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("f_orphan_sticky", err_orphan, 1'b1);
        @(negedge clk);
        rd_req = 4'b0001;
        wait_req("f_rd_req");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("f_rst_req", sdram_req, 1'b0);
        check("f_rst_orphan", err_orphan, 1'b0);
        check("f_rst_pending", pending_cnt, 0);
        reset  = 1'b0;
        rd_req = '0;

        // Randomized traffic against the transaction-level model.
        do_reset();
        mq.delete();
        busy          = 0;
        bport         = 0;
        baddr         = '0;
        bdata         = '0;
        rr            = 0;
        acked_last    = '0;
        dl_acked_last = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) begin
                if (acked_last[i] || !rd_req[i]) begin
                    rd_req[i] = ($urandom_range(0, 3) == 0);
                    if (rd_req[i]) rd_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            if (dl_acked_last || !dl_req) begin
                dl_req = ($urandom_range(0, 4) == 0);
                if (dl_req) begin
                    dl_addr = AW'($urandom);
                    dl_data = $urandom;
                end
            end
            if ($urandom_range(0, 19) == 0) dl_active = ~dl_active;
            sdram_ack   = ($urandom_range(0, 1) == 1);
            sdram_valid = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
            #1;
            e_rd_ack = (busy == 1 && sdram_ack) ? (NP'(1) << bport) : '0;
            e_dl_ack = (busy == 2 && sdram_ack);
            e_valid  = (sdram_valid && mq.size() > 0) ? (NP'(1) << mq[0]) : '0;
            check("r_req", sdram_req, busy != 0);
            check("r_rd_ack", rd_ack, e_rd_ack);
            check("r_dl_ack", dl_ack, e_dl_ack);
            check("r_rd_valid", rd_valid, e_valid);
            check("r_pending", pending_cnt, mq.size());
            check("r_orphan", err_orphan, 1'b0);
            if (busy != 0) begin
                check("r_addr", sdram_addr, baddr);
                check("r_we", sdram_we, busy == 2);
            end
            if (busy == 2) check("r_data", sdram_data, bdata);

            acked_last    = e_rd_ack;
            dl_acked_last = e_dl_ack;
            occ           = mq.size();
            if (sdram_valid && mq.size() > 0) void'(mq.pop_front());
            if (busy == 1 && sdram_ack) begin
                mq.push_back(bport);
                rr   = (bport + 1) % NP;
                busy = 0;
            end else if (busy == 2 && sdram_ack) begin
                busy = 0;
            end else if (busy == 0) begin
                if (dl_active && dl_req) begin
                    busy  = 2;
                    baddr = dl_addr;
                    bdata = dl_data;
                end else if (!dl_active && occ < MP && rd_req != '0) begin
                    for (int k = 0; k < NP; k++) begin
                        if (busy == 0 && rd_req[(rr + k) % NP]) begin
                            busy  = 1;
                            bport = (rr + k) % NP;
                            baddr = rd_addr[bport*AW +: AW];
                        end
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single 32-bit SDRAM controller port between NUM_PORTS read requesters (ROM segments) and the ROM download writer.
- Grants requesters round-robin. Download writes take absolute priority.
- Keeps an in-order FIFO of grant tags so each sdram_valid is routed to the requester that issued that read, even with several reads outstanding.
- Sits between the ROM segment caches and the SDRAM controller, replacing ad-hoc priority muxing.

Parameters:
- NUM_PORTS, 4: number of read requesters (2..8).
- ADDR_WIDTH, 23: SDRAM word address width.
- DATA_WIDTH, 32: SDRAM data width.
- MAX_PENDING, 4: maximum outstanding reads (tag FIFO depth, power of two).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset.
- rd_req  in  NUM_PORTS  per-port read request, level; held until that port's rd_ack.
- rd_addr  in  NUM_PORTS*ADDR_WIDTH  flattened per-port word addresses; port i is bits [i*ADDR_WIDTH +: ADDR_WIDTH]; stable while rd_req is high.
- rd_ack  out  NUM_PORTS  one-cycle pulse: request accepted by SDRAM.
- rd_valid  out  NUM_PORTS  one-cycle pulse: sdram_q holds data for this port.
- dl_active  in  1  download in progress (ioctl_download).
- dl_req  in  1  download write request, level.
- dl_addr  in  ADDR_WIDTH  download word address.
- dl_data  in  DATA_WIDTH  download write data.
- dl_ack  out  1  one-cycle pulse: write accepted.
- sdram_addr  out  ADDR_WIDTH  registered address to controller.
- sdram_data  out  DATA_WIDTH  registered write data.
- sdram_we  out  1  registered write enable.
- sdram_req  out  1  registered request.
- sdram_ack  in  1  controller accepted current request.
- sdram_valid  in  1  controller read data valid (in issue order).
- pending_cnt  out  clog2(MAX_PENDING)+1  outstanding read count.
- err_orphan  out  1  sticky: sdram_valid arrived with empty FIFO.

Behaviour:
- Reset: synchronous, active-high. All outputs 0. State IDLE. RR pointer 0. FIFO empty. err_orphan cleared.
- States:
  - IDLE: choose a grant each cycle.
  - ISSUE_RD: sdram_req=1, sdram_we=0, registered rd_addr of the granted port; wait for sdram_ack.
  - ISSUE_WR: sdram_req=1, sdram_we=1, registered dl_addr/dl_data; wait for sdram_ack.
- IDLE grant priority:
  1. dl_active & dl_req → ISSUE_WR.
  2. Else, if !dl_active and FIFO not full and any rd_req → grant the first requesting port at or after the RR pointer (modulo NUM_PORTS) → ISSUE_RD.
  3. Else stay in IDLE with sdram_req=0.
- Latency: request seen in IDLE at cycle N → sdram_req high at N+1. Address/data/we are registered in the same cycle as the grant.
- ISSUE_*: sdram_req held high until sdram_ack.
- On sdram_ack in ISSUE_RD:
  - rd_ack[grant] is driven combinationally from sdram_ack in the same cycle.
  - Push grant index into FIFO.
  - RR pointer ← grant+1 (wraps at NUM_PORTS).
  - sdram_req=0 next cycle; return to IDLE.
  - Earliest next grant is the cycle after ack.
- On sdram_ack in ISSUE_WR: dl_ack pulses in the same cycle; no FIFO push; return to IDLE.
- sdram_valid with FIFO non-empty: rd_valid[head] = 1 combinationally in the same cycle; pop.
- sdram_valid with FIFO empty: no rd_valid pulse; err_orphan ← 1.
- Simultaneous push and pop: FIFO occupancy unchanged; pending_cnt unchanged.
- FIFO full: no new read grants. Writes are still allowed.
- rd_req dropping during ISSUE_RD is a protocol violation; the arbiter keeps the request until ack.
- dl_active rising during ISSUE_RD: the read completes normally; reads are blocked from the next IDLE onward.
- Reset mid-operation: sdram_req=0 on the next edge; FIFO flushed; late sdram_valid is ignored (err_orphan still cleared by reset only on the reset cycle itself).
- sdram_q is not routed through this block; consumers tap it directly, qualified by rd_valid.

Decomposition:
- Shared include sdram_arb_defs.vh: state encodings (IDLE=0, ISSUE_RD=1, ISSUE_WR=2) and TAG_W = clog2(NUM_PORTS).
- One sub-module, tag_fifo: synchronous FIFO, width TAG_W, depth MAX_PENDING.
  - Ports: push, pop, din, dout, full, empty, count.
  - Same-cycle push/pop allowed when full or empty: when empty, pop is ignored; when full, push is allowed only together with pop.

Test Plan:
- Reset, then rd_req=4'b0101, addrs 0x100/0x300, sdram_ack 2 cycles after sdram_req → port0 acked first (sdram_addr=0x100), then port2 (0x300); RR pointer=3.
- All four ports request continuously; controller acks each in 1 cycle → grant order 0,1,2,3,0; each rd_ack a single pulse; never two grants without an intervening IDLE cycle.
- MAX_PENDING=4: issue 4 reads with no sdram_valid → pending_cnt=4; a 5th rd_req gets no sdram_req until one sdram_valid arrives; then 4 valids route to ports in issue order.
- sdram_ack for a new read in the same cycle as sdram_valid for an older read → rd_valid to the older port, rd_ack to the new one; pending_cnt unchanged.
- dl_active=1, dl_req with dl_addr=0x1234, dl_data=0xDEADBEEF while rd_req=1 → sdram_we=1 with those values; rd_req stays unacked until dl_active=0.
- sdram_valid with FIFO empty → no rd_valid pulse; err_orphan=1 until reset; a reset pulse mid-ISSUE_RD → sdram_req=0 on the next edge.
